// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - SAR ADC sequencer: mux select, sample/hold, DAC bit trials,
// synchronised comparator readback and valid/ready result delivery, single or round-robin scan.
module sar_adc_ctrl #(
  parameter int WIDTH      = 8,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 4,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CHW-1:0]   ch_sel,
  input  logic             scan_en,
  input  logic             cmp_in,
  output logic [CHW-1:0]   mux_sel,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] res_data,
  output logic [CHW-1:0]   res_ch,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int MAXC = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam int BW   = $clog2(WIDTH);
  localparam logic [CNTW-1:0] SAMPLE_LAST = CNTW'(SAMPLE_CYC - 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0]   MSB_IDX     = BW'(WIDTH - 1);
  localparam logic [CHW:0]    NCH_W       = (CHW + 1)'(NCH);
  localparam logic [CHW-1:0]  LAST_CH     = CHW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sar_q, sar_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [CHW-1:0]   scan_ptr_q, scan_ptr_d;
  logic             scan_conv_q, scan_conv_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CHW-1:0]   res_ch_q, res_ch_d;
  logic             cmp_meta_q, cmp_s_q;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] sar_upd;

  // trial code = bits already decided plus the bit under test
  assign trial   = sar_q | (WIDTH'(1) << bit_q);
  assign sar_upd = cmp_s_q ? trial : sar_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sar_d       = sar_q;
    ch_d        = ch_q;
    scan_ptr_d  = scan_ptr_q;
    scan_conv_d = scan_conv_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    case (state_q)
      S_IDLE: begin
        if (scan_en || start) begin
          state_d     = S_SAMPLE;
          cnt_d       = '0;
          sar_d       = '0;
          scan_conv_d = scan_en;
          if (scan_en)                    ch_d = scan_ptr_q;
          else if ({1'b0, ch_sel} >= NCH_W) ch_d = '0;
          else                            ch_d = ch_sel;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
          bit_d   = MSB_IDX;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_CONVERT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          sar_d = sar_upd;
          if (bit_q == '0) begin
            state_d    = S_DONE;
            res_data_d = sar_upd;
            res_ch_d   = ch_q;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          if (scan_conv_q)
            scan_ptr_d = (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + CHW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sar_q       <= '0;
      ch_q        <= '0;
      scan_ptr_q  <= '0;
      scan_conv_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      cmp_meta_q  <= 1'b0;
      cmp_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sar_q       <= sar_d;
      ch_q        <= ch_d;
      scan_ptr_q  <= scan_ptr_d;
      scan_conv_q <= scan_conv_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      cmp_meta_q  <= cmp_in;
      cmp_s_q     <= cmp_meta_q;
    end
  end

  assign mux_sel   = ch_q;
  assign sample    = (state_q == S_SAMPLE);
  assign dac_code  = (state_q == S_CONVERT) ? trial : '0;
  assign busy      = (state_q != S_IDLE);
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign res_valid = (state_q == S_DONE);

endmodule
